// File: rtl/pc_context_unit.sv
// Program-counter / fetch-source unit: BIOS and process PCs, context switching on instruction boundaries.
// Optional RETIRE_COUNT_EN adds the proc_retired counter of process retirements.
module pc_context_unit #(
   parameter int          BIOS_ADDR_W   = 8,
   parameter int unsigned BIOS_RESET_PC = 0,
   parameter logic [31:0] PROC_RESET_PC = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  bios_state,
   input  logic        done_inst,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        proc_pc_load,
   input  logic [31:0] proc_pc_value,
   input  logic [31:0] bios_instr,
   input  logic [31:0] mem_instr,
   output logic [31:0] pc,
   output logic [31:0] instruction,
   output logic        in_bios,
   output logic [31:0] proc_pc,
`ifdef RETIRE_COUNT_EN
   output logic [31:0] proc_retired,
`endif
   output logic        switch_pulse
);

   typedef enum logic {M_BIOS, M_PROC} mode_t;

   localparam logic [BIOS_ADDR_W-1:0] BIOS_RST = BIOS_ADDR_W'(BIOS_RESET_PC);
   localparam logic [BIOS_ADDR_W-1:0] BIOS_ONE = {{(BIOS_ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [31-BIOS_ADDR_W:0] ZEXT    = '0;

   mode_t                  mode;
   logic [BIOS_ADDR_W-1:0] bios_pc;
   logic [BIOS_ADDR_W-1:0] bios_adv;
   logic [31:0]            proc_adv;
   logic                   req_proc;

   // PROCESSEXEC and PROCESSINT both request the process context
   assign req_proc    = bios_state[1];
   assign bios_adv    = branch_taken ? branch_target[BIOS_ADDR_W-1:0] : bios_pc + BIOS_ONE;
   assign proc_adv    = branch_taken ? branch_target : proc_pc + 32'd1;
   assign instruction = in_bios ? bios_instr : mem_instr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode         <= M_BIOS;
         in_bios      <= 1'b1;
         bios_pc      <= BIOS_RST;
         proc_pc      <= PROC_RESET_PC;
         pc           <= {ZEXT, BIOS_RST};
         switch_pulse <= 1'b0;
`ifdef RETIRE_COUNT_EN
         proc_retired <= 32'd0;
`endif
      end else begin
         switch_pulse <= 1'b0;
         case (mode)
            M_BIOS: begin
               if (proc_pc_load)
                  proc_pc <= proc_pc_value;
               if (done_inst) begin
                  bios_pc <= bios_adv;
                  if (req_proc) begin
                     // a load on the launching edge supplies the resume PC
                     mode         <= M_PROC;
                     in_bios      <= 1'b0;
                     switch_pulse <= 1'b1;
                     pc           <= proc_pc_load ? proc_pc_value : proc_pc;
`ifdef RETIRE_COUNT_EN
                     proc_retired <= 32'd0;
`endif
                  end else begin
                     pc <= {ZEXT, bios_adv};
                  end
               end
            end
            M_PROC: begin
               if (done_inst) begin
                  proc_pc <= proc_adv;
`ifdef RETIRE_COUNT_EN
                  proc_retired <= proc_retired + 32'd1;
`endif
                  if (!req_proc) begin
                     mode         <= M_BIOS;
                     in_bios      <= 1'b1;
                     switch_pulse <= 1'b1;
                     pc           <= {ZEXT, bios_pc};
                  end else begin
                     pc <= proc_adv;
                  end
               end
            end
            default: begin
               mode    <= M_BIOS;
               in_bios <= 1'b1;
               pc      <= {ZEXT, bios_pc};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_context_unit.sv
// Randomized bench for pc_context_unit against a context-array reference model.
module tb_pc_context_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  bios_state;
   logic        done_inst, branch_taken, proc_pc_load;
   logic [31:0] branch_target, proc_pc_value, bios_instr, mem_instr;
   logic [31:0] pc, instruction, proc_pc;
   logic        in_bios, switch_pulse;
`ifdef RETIRE_COUNT_EN
   logic [31:0] proc_retired;
`endif

   pc_context_unit dut (
      .clk(clk), .reset(reset), .bios_state(bios_state), .done_inst(done_inst),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .proc_pc_load(proc_pc_load), .proc_pc_value(proc_pc_value),
      .bios_instr(bios_instr), .mem_instr(mem_instr), .pc(pc),
      .instruction(instruction), .in_bios(in_bios), .proc_pc(proc_pc),
`ifdef RETIRE_COUNT_EN
      .proc_retired(proc_retired),
`endif
      .switch_pulse(switch_pulse)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // reference: ctx 0 = BIOS, ctx 1 = process; m_pc[ctx] is that context's PC
   logic [31:0] m_pc [2];
   int          m_cur;
   bit          m_pulse;
   logic [31:0] m_ret;

   function automatic void m_reset();
      m_pc[0] = 0; m_pc[1] = 0; m_cur = 0; m_pulse = 0; m_ret = 0;
   endfunction

   task automatic model_edge();
      int req;
      logic [31:0] nx;
      req = (bios_state >= 2) ? 1 : 0;
      m_pulse = 0;
      if (m_cur == 0 && proc_pc_load) m_pc[1] = proc_pc_value;
      if (done_inst) begin
         nx = branch_taken ? branch_target : m_pc[m_cur] + 1;
         if (m_cur == 0) nx = nx % 256;
         m_pc[m_cur] = nx;
         if (m_cur == 1) m_ret = m_ret + 1;
         if (req != m_cur) begin
            if (m_cur == 0) m_ret = 0;
            m_cur = req;
            m_pulse = 1;
         end
      end
   endtask

   task automatic check_all(input string w);
      chk({w, ".pc"}, pc, m_pc[m_cur]);
      chk({w, ".in_bios"}, {31'd0, in_bios}, (m_cur == 0) ? 32'd1 : 32'd0);
      chk({w, ".proc_pc"}, proc_pc, m_pc[1]);
      chk({w, ".pulse"}, {31'd0, switch_pulse}, {31'd0, m_pulse});
      chk({w, ".instr"}, instruction, (m_cur == 0) ? bios_instr : mem_instr);
`ifdef RETIRE_COUNT_EN
      chk({w, ".retired"}, proc_retired, m_ret);
`endif
   endtask

   task automatic step(input logic [1:0] st, input bit dn, input bit br,
                       input logic [31:0] tgt, input bit ld, input logic [31:0] val);
      @(negedge clk);
      bios_state = st; done_inst = dn; branch_taken = br; branch_target = tgt;
      proc_pc_load = ld; proc_pc_value = val;
      bios_instr = $urandom; mem_instr = $urandom;
      @(posedge clk);
      model_edge();
      #1 check_all("step");
   endtask

   // reset pulse placed between edges to exercise the asynchronous path
   task automatic do_reset();
      @(negedge clk);
      done_inst = 0; proc_pc_load = 0;
      #2 reset = 1;
      #1 m_reset();
      check_all("rst");
      #1 reset = 0;
   endtask

   initial begin
      reset = 1; bios_state = 0; done_inst = 0; branch_taken = 0; branch_target = 0;
      proc_pc_load = 0; proc_pc_value = 0; bios_instr = 32'hB105_0000; mem_instr = 32'h4E40_0000;
      m_reset();
      #3 check_all("init");
      chk("init.pc0", pc, 32'd0);
      #9 reset = 0;

      // BIOS run and 8-bit wrap
      step(1, 1, 0, 0, 0, 0); chk("t2.pc1", pc, 32'd1);
      step(1, 1, 0, 0, 0, 0); chk("t2.pc2", pc, 32'd2);
      step(1, 1, 0, 0, 0, 0); chk("t2.pc3", pc, 32'd3);
      step(1, 1, 1, 32'd255, 0, 0); chk("t2.pc255", pc, 32'd255);
      step(1, 1, 0, 0, 0, 0); chk("t2.wrap", pc, 32'd0);

      // launch
      step(1, 1, 1, 32'h6D, 0, 0); chk("t3.bpc", pc, 32'h6D);
      step(1, 0, 0, 0, 1, 32'h40); chk("t3.load", proc_pc, 32'h40);
      step(2, 1, 0, 0, 0, 0);
      chk("t3.pc", pc, 32'h40); chk("t3.pulse", {31'd0, switch_pulse}, 32'd1);
      step(2, 0, 0, 0, 0, 0); chk("t3.pulse_off", {31'd0, switch_pulse}, 32'd0);

      // preempt: request changes but no boundary yet
      repeat (5) step(2, 1, 0, 0, 0, 0);
      chk("t4.pc45", pc, 32'h45);
      step(3, 0, 0, 0, 0, 0); step(3, 0, 0, 0, 0, 0);
      repeat (4) step(1, 0, 0, 0, 0, 0);
      chk("t4.hold", pc, 32'h45); chk("t4.mode", {31'd0, in_bios}, 32'd0);
      step(1, 1, 0, 0, 0, 0);
      chk("t4.pc", pc, 32'h6E); chk("t4.ppc", proc_pc, 32'h46);

      // 32-bit wrap, branch on switching edge, load ignored in PROC
      step(1, 0, 0, 0, 1, 32'hFFFF_FFFF);
      step(2, 1, 0, 0, 0, 0); chk("t5.max", pc, 32'hFFFF_FFFF);
      step(2, 1, 0, 0, 0, 0); chk("t5.wrap", pc, 32'd0);
      step(2, 0, 0, 0, 1, 32'h1234); chk("t5.noload", proc_pc, 32'd0);
      step(1, 1, 1, 32'h80, 0, 0);
      chk("t5.saved", proc_pc, 32'h80); chk("t5.bpc", pc, 32'h6F);

`ifdef RETIRE_COUNT_EN
      step(2, 1, 0, 0, 0, 0); chk("t6.clr", proc_retired, 32'd0);
      repeat (4) step(2, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0); chk("t6.five", proc_retired, 32'd5);
      repeat (2) step(1, 1, 0, 0, 0, 0);
      chk("t6.hold", proc_retired, 32'd5);
      step(2, 1, 0, 0, 0, 0); chk("t6.reclr", proc_retired, 32'd0);
`endif

      // reset mid-run
      step(2, 1, 0, 0, 0, 0);
      do_reset();
      chk("t1.pc", pc, 32'd0); chk("t1.in_bios", {31'd0, in_bios}, 32'd1);
      chk("t1.proc_pc", proc_pc, 32'd0); chk("t1.pulse", {31'd0, switch_pulse}, 32'd0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 63) == 0) do_reset();
         else step(2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3) == 0,
                   ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2) : $urandom,
                   $urandom_range(0, 4) == 0, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
